// File: rtl/ndp_depth_tracker.sv
// Per-port egress queue depth estimator for NDP-style trimming.
// Tracks the estimated depth, trims oversize arrivals, and ECN-marks under congestion with hysteresis.
module ndp_depth_tracker #(
  parameter int NUM_PORTS   = 8,
  parameter int DEPTH_WIDTH = 16,
  parameter int LEN_WIDTH   = 12,
  parameter int DRAIN_RATE  = 64,
  parameter int MAX_DEPTH   = 4096,
  parameter int TRIM_LEN    = 64,
  parameter int HI_THRESH   = 2048,
  parameter int LO_THRESH   = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             in_valid,
  input  logic [NUM_PORTS*LEN_WIDTH-1:0]   in_len,
  input  logic [NUM_PORTS-1:0]             drain_en,
  input  logic                             clr_cnt,
  output logic [NUM_PORTS-1:0]             out_valid,
  output logic [NUM_PORTS-1:0]             out_trim,
  output logic [NUM_PORTS-1:0]             out_mark,
  output logic [NUM_PORTS*DEPTH_WIDTH-1:0] depth_out,
  output logic [NUM_PORTS*32-1:0]          trim_cnt
);

  localparam int EW = DEPTH_WIDTH + 1;

  // One spare bit so depth + length can be compared and summed without wrapping.
  localparam logic [EW-1:0] MAX_D     = EW'(MAX_DEPTH);
  localparam logic [EW-1:0] TRIM_L    = EW'(TRIM_LEN);
  localparam logic [EW-1:0] DRAIN_R   = EW'(DRAIN_RATE);
  localparam logic [EW-1:0] HI_T      = EW'(HI_THRESH);
  localparam logic [EW-1:0] LO_T      = EW'(LO_THRESH);
  localparam logic [EW-1:0] DEPTH_SAT = {1'b0, {DEPTH_WIDTH{1'b1}}};

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [DEPTH_WIDTH-1:0] depth_q;
    logic                   cong_q;
    logic                   valid_q;
    logic                   trim_q;
    logic                   mark_q;
    logic [31:0]            cnt_q;

    logic [EW-1:0]          len_ext;
    logic [EW-1:0]          added;
    logic [EW-1:0]          sum;
    logic [EW-1:0]          drained;
    logic [DEPTH_WIDTH-1:0] next_depth;
    logic                   trim;
    logic                   mark;
    logic                   next_cong;

    always_comb begin
      len_ext = EW'(in_len[i*LEN_WIDTH +: LEN_WIDTH]);
      trim    = in_valid[i] && (({1'b0, depth_q} + len_ext) > MAX_D);
      mark    = in_valid[i] && cong_q && !trim;

      added = '0;
      if (in_valid[i]) begin
        added = trim ? TRIM_L : len_ext;
      end
      sum = {1'b0, depth_q} + added;

      drained = sum;
      if (drain_en[i]) begin
        drained = (sum > DRAIN_R) ? (sum - DRAIN_R) : '0;
      end
      next_depth = (drained > DEPTH_SAT) ? '1 : drained[DEPTH_WIDTH-1:0];

      // Hysteresis: between the two levels the previous state is kept.
      next_cong = cong_q;
      if ({1'b0, next_depth} >= HI_T) begin
        next_cong = 1'b1;
      end else if ({1'b0, next_depth} < LO_T) begin
        next_cong = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        depth_q <= '0;
        cong_q  <= 1'b0;
        valid_q <= 1'b0;
        trim_q  <= 1'b0;
        mark_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        depth_q <= next_depth;
        cong_q  <= next_cong;
        valid_q <= in_valid[i];
        trim_q  <= trim;
        mark_q  <= mark;
        // A clear coinciding with a trim still counts that trim.
        if (clr_cnt) begin
          cnt_q <= trim ? 32'd1 : 32'd0;
        end else if (trim && (cnt_q != 32'hFFFF_FFFF)) begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
    end

    assign out_valid[i]                            = valid_q;
    assign out_trim[i]                             = trim_q;
    assign out_mark[i]                             = mark_q;
    assign depth_out[i*DEPTH_WIDTH +: DEPTH_WIDTH] = depth_q;
    assign trim_cnt[i*32 +: 32]                    = cnt_q;
  end

endmodule

// File: tb/tb_ndp_depth_tracker.sv
// Self-checking bench for ndp_depth_tracker: a per-port arithmetic model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ndp_depth_tracker;

  localparam int NP = 8;
  localparam int LW = 12;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP-1:0]     in_valid = '0;
  logic [NP*LW-1:0]  in_len = '0;
  logic [NP-1:0]     drain_en = '1;
  logic              clr_cnt = 1'b0;
  logic [NP-1:0]     out_valid;
  logic [NP-1:0]     out_trim;
  logic [NP-1:0]     out_mark;
  logic [NP*DW-1:0]  depth_out;
  logic [NP*32-1:0]  trim_cnt;

  int checks = 0;
  int failures = 0;

  ndp_depth_tracker #(
    .NUM_PORTS(NP), .DEPTH_WIDTH(DW), .LEN_WIDTH(LW), .DRAIN_RATE(64),
    .MAX_DEPTH(4096), .TRIM_LEN(64), .HI_THRESH(2048), .LO_THRESH(1024)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_len(in_len),
    .drain_en(drain_en), .clr_cnt(clr_cnt), .out_valid(out_valid),
    .out_trim(out_trim), .out_mark(out_mark), .depth_out(depth_out),
    .trim_cnt(trim_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer queue-depth bookkeeping per port.
  int     m_depth [NP] = '{default: 0};
  bit     m_cong  [NP] = '{default: 0};
  bit     m_valid [NP] = '{default: 0};
  bit     m_trim  [NP] = '{default: 0};
  bit     m_mark  [NP] = '{default: 0};
  longint m_cnt   [NP] = '{default: 0};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        m_depth[p] = 0; m_cong[p] = 0; m_valid[p] = 0;
        m_trim[p] = 0; m_mark[p] = 0; m_cnt[p] = 0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        int len, s;
        bit t;
        len = int'(in_len[p*LW +: LW]);
        t = in_valid[p] && (m_depth[p] + len > 4096);
        s = m_depth[p] + (!in_valid[p] ? 0 : (t ? 64 : len));
        if (drain_en[p]) s = (s > 64) ? s - 64 : 0;
        if (s > 65535) s = 65535;
        m_valid[p] = in_valid[p];
        m_trim[p]  = t;
        m_mark[p]  = in_valid[p] && m_cong[p] && !t;
        if (s >= 2048) m_cong[p] = 1;
        else if (s < 1024) m_cong[p] = 0;
        m_depth[p] = s;
        if (clr_cnt) m_cnt[p] = t ? 1 : 0;
        else if (t && m_cnt[p] < 64'hFFFF_FFFF) m_cnt[p] = m_cnt[p] + 1;
      end
    end
  end

  task automatic check_output(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) begin
      check_output($sformatf("depth[%0d]", p), longint'(depth_out[p*DW +: DW]), m_depth[p]);
      check_output($sformatf("valid[%0d]", p), longint'(out_valid[p]), m_valid[p]);
      check_output($sformatf("trim[%0d]", p), longint'(out_trim[p]), m_trim[p]);
      check_output($sformatf("mark[%0d]", p), longint'(out_mark[p]), m_mark[p]);
      check_output($sformatf("cnt[%0d]", p), longint'(trim_cnt[p*32 +: 32]), m_cnt[p]);
    end
  end

  task automatic set_port(int p, int len);
    in_valid[p] = 1'b1;
    in_len[p*LW +: LW] = LW'(len);
  endtask

  // Lets the staged inputs take effect on one edge, then returns single-cycle strobes to idle.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    in_valid = '0;
    clr_cnt  = 1'b0;
  endtask

  function automatic longint dep(int p);
    return longint'(depth_out[p*DW +: DW]);
  endfunction

  function automatic longint cnt(int p);
    return longint'(trim_cnt[p*32 +: 32]);
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_depth", longint'(depth_out), 0);
    check_output("reset_cnt", longint'(trim_cnt != '0), 0);
    check_output("reset_valid", longint'(out_valid), 0);
    rst = 1'b1;

    // Single 1500-byte packet drains to empty after 23 idle cycles.
    set_port(0, 1500);
    apply_stimulus();
    check_output("t1_depth", dep(0), 1436);
    check_output("t1_valid", longint'(out_valid[0]), 1);
    check_output("t1_trim", longint'(out_trim[0]), 0);
    check_output("t1_mark", longint'(out_mark[0]), 0);
    repeat (22) apply_stimulus();
    check_output("t1_depth22", dep(0), 28);
    apply_stimulus();
    check_output("t1_depth23", dep(0), 0);
    repeat (3) apply_stimulus();
    check_output("t1_hold", dep(0), 0);

    // Paused port fills to 4000, then a 200-byte arrival gets trimmed.
    drain_en[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin set_port(0, 1000); apply_stimulus(); end
    check_output("t2_build", dep(0), 4000);
    set_port(0, 200);
    apply_stimulus();
    check_output("t2_trim", longint'(out_trim[0]), 1);
    check_output("t2_depth", dep(0), 4064);
    check_output("t2_cnt", cnt(0), 1);
    check_output("t2_mark", longint'(out_mark[0]), 0);
    drain_en[0] = 1'b1;

    // Hysteresis on port 1.
    drain_en[1] = 1'b0;
    set_port(1, 1024); apply_stimulus();
    set_port(1, 1024); apply_stimulus();
    check_output("t3_depth2048", dep(1), 2048);
    check_output("t3_mark_first", longint'(out_mark[1]), 0);
    set_port(1, 10); apply_stimulus();
    check_output("t3_mark_hi", longint'(out_mark[1]), 1);
    drain_en[1] = 1'b1;
    repeat (9) apply_stimulus();
    check_output("t3_depth1482", dep(1), 1482);
    set_port(1, 0); apply_stimulus();
    check_output("t3_mark_mid", longint'(out_mark[1]), 1);
    check_output("t3_depth1418", dep(1), 1418);
    repeat (7) apply_stimulus();
    check_output("t3_depth970", dep(1), 970);
    set_port(1, 0); apply_stimulus();
    check_output("t3_mark_lo", longint'(out_mark[1]), 0);
    check_output("t3_depth906", dep(1), 906);

    // Counter clear coinciding with a trim on port 3.
    drain_en[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin set_port(3, 1000); apply_stimulus(); end
    set_port(3, 200);
    clr_cnt = 1'b1;
    apply_stimulus();
    check_output("t4_cnt3", cnt(3), 1);
    check_output("t4_cnt0", cnt(0), 0);
    check_output("t4_cnt1", cnt(1), 0);
    drain_en[3] = 1'b1;

    // Port 2 trims every cycle until depth saturates.
    drain_en[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin set_port(2, 1000); apply_stimulus(); end
    set_port(2, 200); apply_stimulus();
    check_output("t5_start", dep(2), 4064);
    for (int k = 0; k < 960; k++) begin set_port(2, 1500); apply_stimulus(); end
    check_output("t5_near", dep(2), 65504);
    set_port(2, 1500); apply_stimulus();
    check_output("t5_sat", dep(2), 65535);
    set_port(2, 1500); apply_stimulus();
    check_output("t5_hold", dep(2), 65535);
    check_output("t5_trim", longint'(out_trim[2]), 1);
    drain_en[2] = 1'b1;

    // Pseudo-random traffic on all ports, checked by the model.
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) != 0) set_port(p, int'($urandom_range(0, 4095)));
        drain_en[p] = ($urandom_range(0, 3) != 0);
      end
      clr_cnt = ($urandom_range(0, 40) == 0);
      apply_stimulus();
    end

    // Asynchronous reset in the middle of a burst.
    drain_en = '1;
    for (int k = 0; k < 3; k++) begin
      for (int p = 0; p < NP; p++) set_port(p, 300);
      apply_stimulus();
    end
    for (int p = 0; p < NP; p++) set_port(p, 300);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_output("t6_valid", longint'(out_valid), 0);
    check_output("t6_trim", longint'(out_trim), 0);
    check_output("t6_mark", longint'(out_mark), 0);
    check_output("t6_depth", longint'(depth_out != '0), 0);
    check_output("t6_cnt", longint'(trim_cnt != '0), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = '0;
    set_port(0, 100);
    apply_stimulus();
    check_output("t6_first_depth", dep(0), 36);
    check_output("t6_first_valid", longint'(out_valid), 1);
    check_output("t6_first_other", dep(1), 0);
    check_output("t6_first_trim", longint'(out_trim[0]), 0);
    repeat (2) apply_stimulus();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ndp_depth_tracker.md
NDP_DEPTH_TRACKER -- requirements
Module: ndp_depth_tracker

Interface
REQ-001 Parameter NUM_PORTS, default 8, number of tracked egress queues.
REQ-002 Parameter DEPTH_WIDTH, default 16, estimated-depth width in bytes.
REQ-003 Parameter LEN_WIDTH, default 12, packet-length width in bytes.
REQ-004 Parameter DRAIN_RATE, default 64, bytes drained per port per cycle when drain enabled.
REQ-005 Parameter MAX_DEPTH, default 4096, trim threshold in bytes.
REQ-006 Parameter TRIM_LEN, default 64, bytes charged for a trimmed (header-only) packet.
REQ-007 Parameters HI_THRESH = 2048 and LO_THRESH = 1024 (defaults), congestion set/clear levels; LO_THRESH < HI_THRESH required.
REQ-008 clk  input  1  single clock, all state on rising edge.
REQ-009 rst  input  1  reset, asynchronous, active-low.
REQ-010 in_valid  input  NUM_PORTS  per-port packet-arrival strobe.
REQ-011 in_len  input  NUM_PORTS*LEN_WIDTH  per-port packet length; port i in bits [i*LEN_WIDTH +: LEN_WIDTH].
REQ-012 drain_en  input  NUM_PORTS  per-port drain enable (low = port paused).
REQ-013 clr_cnt  input  1  synchronous clear of all trim counters.
REQ-014 out_valid  output  NUM_PORTS  registered copy of in_valid.
REQ-015 out_trim  output  NUM_PORTS  trim decision for the packet flagged by out_valid.
REQ-016 out_mark  output  NUM_PORTS  congestion (ECN) mark for the packet flagged by out_valid.
REQ-017 depth_out  output  NUM_PORTS*DEPTH_WIDTH  current depth estimate per port.
REQ-018 trim_cnt  output  NUM_PORTS*32  per-port saturating trimmed-packet count.

Function
REQ-019 Ports are independent; all per-port logic is replicated NUM_PORTS times via generate.
REQ-020 Trim decision for port i in cycle t: trim = in_valid[i] and (depth + in_len > MAX_DEPTH), evaluated in DEPTH_WIDTH+1 bits on depth before update.
REQ-021 Added bytes: 0 if no valid; in_len if valid and not trim; TRIM_LEN if valid and trim.
REQ-022 sum = depth + added in DEPTH_WIDTH+1 bits; if drain_en[i], next = (sum > DRAIN_RATE) ? sum - DRAIN_RATE : 0; else next = sum.
REQ-023 next saturates at 2^DEPTH_WIDTH - 1; depth never wraps.
REQ-024 depth_out reflects next one cycle after inputs.
REQ-025 Congested flag per port: set when next >= HI_THRESH; cleared when next < LO_THRESH; otherwise held (hysteresis).
REQ-026 out_mark[i] = in_valid[i] and (congested flag before update) and not trim, registered; trimmed packets are never marked.
REQ-027 out_valid, out_trim, out_mark are single-cycle pulses with latency exactly 1 cycle; back-to-back arrivals every cycle are supported.
REQ-028 trim_cnt[i] increments by 1 per trim, saturating at 0xFFFFFFFF.
REQ-029 clr_cnt with simultaneous trim on a port yields trim_cnt = 1 for that port; clr_cnt alone yields 0.
REQ-030 in_len = 0 with in_valid is legal: adds 0, never trims.

Reset
REQ-031 rst low asynchronously forces depth, congested flags, out_valid, out_trim, out_mark, trim_cnt to 0 without a clock edge.
REQ-032 rst deassertion is synchronised externally; first update occurs on the first rising edge with rst high; arrivals during reset are discarded.

Verification
REQ-033 Port 0, depth 0, drain_en=1, in_len 1500 once -> next cycle depth 1436, out_valid[0]=1, out_trim[0]=0, out_mark[0]=0; after 23 idle cycles depth 0 and holds.
REQ-034 drain_en[0]=0, build depth 4000, then in_len 200 -> out_trim[0]=1, depth 4064, trim_cnt[0]=1, out_mark[0]=0.
REQ-035 drain_en[1]=0, raise depth to 2048 -> later arrivals marked; drain_en=1 to depth 1500 -> still marked; below 1024 -> unmarked.
REQ-036 drain_en[2]=0, repeated trims from 4064 -> depth rises 64/cycle, reaches 65535 and holds, no wrap.
REQ-037 clr_cnt same cycle as trim on port 3 -> trim_cnt[3]=1; other ports' counters 0.
REQ-038 rst driven low mid-burst between clock edges -> all outputs 0 immediately; release -> depth 0, first arrival treated as from empty queue.
